// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder
// Buffers one A tile and one B tile, then on start drives the left/top edges
// of an N x N systolic array with diagonally skewed operand streams, pulses
// the accumulator clear, controls the array-wide pause and flags completion.
module systolic_edge_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic                    ld_sel,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ld_row,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ld_col,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    acc_clear,
    output logic                    pause,
    output logic [N*DATA_WIDTH-1:0] left_out,
    output logic [N*DATA_WIDTH-1:0] top_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // Counter must hold 2N-2 (last stream step)
    localparam int CW = $clog2(2 * N);

    localparam logic [CW-1:0] STREAM_LAST = CW'(2 * N - 2);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(N - 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [N*DATA_WIDTH-1:0] left_nxt;
    logic [N*DATA_WIDTH-1:0] top_nxt;

    logic [DATA_WIDTH-1:0] a_buf [N][N];
    logic [DATA_WIDTH-1:0] b_buf [N][N];

    logic wr_en;

    assign wr_en = (state == ST_IDLE) && ld_valid
                   && (32'(ld_row) < N) && (32'(ld_col) < N);

    // Next-state and phase counter sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_STREAM;
                cnt_nxt   = '0;
            end
            ST_STREAM: begin
                if (cnt == STREAM_LAST) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Skewed edge values for the upcoming cycle: row/column i lags by i steps.
    // Computed from the next state so the edge registers line up with it.
    always_comb begin
        left_nxt = '0;
        top_nxt  = '0;
        if (state_nxt == ST_STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((32'(cnt_nxt) >= i) && ((32'(cnt_nxt) - i) < N)) begin
                    left_nxt[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][IW'(32'(cnt_nxt) - i)];
                    top_nxt[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf[IW'(32'(cnt_nxt) - i)][i];
                end
            end
        end
    end

    // State, tile buffers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ld_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_clear <= 1'b0;
            pause     <= 1'b1;
            left_out  <= '0;
            top_out   <= '0;
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ld_ready  <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
            acc_clear <= (state_nxt == ST_CLEAR);
            pause     <= !((state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH));
            left_out  <= left_nxt;
            top_out   <= top_nxt;
            if (wr_en) begin
                if (ld_sel) begin
                    b_buf[ld_row][ld_col] <= ld_data;
                end else begin
                    a_buf[ld_row][ld_col] <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder
// Directed and random tile passes; edge streams and control outputs are
// compared against the skew rules, and a behavioural PE array fed by the
// edges is compared against a plain matrix product.
module tb_systolic_edge_feeder;

    localparam int DW       = 16;
    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int PASS_LEN = 3 * N;

    logic            clk;
    logic            reset;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_sel;
    logic [IW-1:0]   ld_row;
    logic [IW-1:0]   ld_col;
    logic [DW-1:0]   ld_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            acc_clear;
    logic            pause;
    logic [N*DW-1:0] left_out;
    logic [N*DW-1:0] top_out;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference tile contents as the feeder should hold them
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    // Behavioural PE array driven by the feeder edges
    logic [DW-1:0] pa     [N][N];
    logic [DW-1:0] pb     [N][N];
    logic [DW-1:0] pe_acc [N][N];

    systolic_edge_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_row    (ld_row),
        .ld_col    (ld_col),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .acc_clear (acc_clear),
        .pause     (pause),
        .left_out  (left_out),
        .top_out   (top_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pe_a_in(int i, int j);
        if (j == 0) return left_out[i*DW +: DW];
        return pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] pe_b_in(int i, int j);
        if (i == 0) return top_out[j*DW +: DW];
        return pb[i-1][j];
    endfunction

    // Output-stationary PE array: multiply-accumulate and pass operands on
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (reset || acc_clear) begin
                    pa[i][j]     <= '0;
                    pb[i][j]     <= '0;
                    pe_acc[i][j] <= '0;
                end else if (!pause) begin
                    pa[i][j]     <= pe_a_in(i, j);
                    pb[i][j]     <= pe_b_in(i, j);
                    pe_acc[i][j] <= pe_acc[i][j] + pe_a_in(i, j) * pe_b_in(i, j);
                end
            end
        end
    end

    function automatic logic [DW-1:0] ref_prod(int i, int j);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + ma[i][k] * mb[k][j];
        return s;
    endfunction

    function automatic logic [DW-1:0] exp_left(int c, int i);
        int t;
        int k;
        t = c - 2;
        k = t - i;
        if (t >= 0 && t <= 2*N-2 && k >= 0 && k < N) return ma[i][k];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_top(int c, int j);
        int t;
        int k;
        t = c - 2;
        k = t - j;
        if (t >= 0 && t <= 2*N-2 && k >= 0 && k < N) return mb[k][j];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c counts from the start-sampling edge; idle forces IDLE values
    task automatic check_cycle(input int c, input bit idle);
        logic e_busy;
        logic e_pause;
        e_busy  = !idle && (c >= 1 && c <= PASS_LEN);
        e_pause = idle || !(c >= 2 && c <= PASS_LEN - 1);
        chk($sformatf("c%0d busy", c), 64'(busy), 64'(e_busy));
        chk($sformatf("c%0d ld_ready", c), 64'(ld_ready), 64'(!e_busy));
        chk($sformatf("c%0d done", c), 64'(done), 64'(!idle && c == PASS_LEN));
        chk($sformatf("c%0d acc_clear", c), 64'(acc_clear), 64'(!idle && c == 1));
        chk($sformatf("c%0d pause", c), 64'(pause), 64'(e_pause));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("c%0d left%0d", c, i), 64'(left_out[i*DW +: DW]),
                idle ? 64'd0 : 64'(exp_left(c, i)));
            chk($sformatf("c%0d top%0d", c, i), 64'(top_out[i*DW +: DW]),
                idle ? 64'd0 : 64'(exp_top(c, i)));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
    endtask

    // Write both reference tiles into the feeder, one element per cycle
    task automatic load_all();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ld_valid = 1'b1;
                    ld_sel   = s[0];
                    ld_row   = IW'(i);
                    ld_col   = IW'(j);
                    ld_data  = (s == 0) ? ma[i][j] : mb[i][j];
                    @(negedge clk);
                end
        ld_valid = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            chk($sformatf("idle%0d busy", n), 64'(busy), 64'd0);
            chk($sformatf("idle%0d done", n), 64'(done), 64'd0);
            chk($sformatf("idle%0d pause", n), 64'(pause), 64'd1);
        end
    endtask

    // inject: 0 plain, 1 write+start while busy, 2 reset mid-stream,
    //         3 element write in the same cycle as start
    task automatic run_pass(input int inject);
        start = 1'b1;
        if (inject == 3) begin
            ld_valid = 1'b1;
            ld_sel   = 1'b1;
            ld_row   = 2'd2;
            ld_col   = 2'd1;
            ld_data  = 16'd11;
            mb[2][1] = 16'd11;
        end
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b0;
        for (int c = 1; c <= PASS_LEN + 1; c++) begin
            check_cycle(c, 1'b0);
            if (c == PASS_LEN)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("result%0d%0d", i, j), 64'(pe_acc[i][j]), 64'(ref_prod(i, j)));
            if (inject == 3 && c == 5)
                chk("ldstart_top1", 64'(top_out[1*DW +: DW]), 64'd11);
            if (inject == 1 && c == 5) begin
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_row   = 2'd0;
                ld_col   = 2'd0;
                ld_data  = 16'd7;
            end
            if (inject == 1 && c == 6) begin
                ld_valid = 1'b0;
                start    = 1'b1;
            end
            if (inject == 1 && c == 7) start = 1'b0;
            if (inject == 2 && c == 6) begin
                reset = 1'b1;
                @(negedge clk);
                check_cycle(7, 1'b1);
                reset = 1'b0;
                clear_model();
                return;
            end
            if (c <= PASS_LEN) @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = '0;
        start    = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_cycle(0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_cycle(0, 1'b1);

        // Identity times B reproduces B
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 16'd1 : 16'd0;
                mb[i][j] = 16'(4*i + j + 1);
            end
        load_all();
        run_pass(0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("ident%0d%0d", i, j), 64'(pe_acc[i][j]), 64'(4*i + j + 1));

        // Skew of isolated A elements
        clear_model();
        ma[1][0] = 16'd5;
        ma[3][3] = 16'd9;
        load_all();
        run_pass(0);

        // Constant tiles, replayed: clear prevents accumulation across passes
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 16'd2;
                mb[i][j] = 16'd3;
            end
        load_all();
        run_pass(0);
        chk("const_pass1", 64'(pe_acc[2][1]), 64'd24);
        run_pass(0);
        chk("const_pass2", 64'(pe_acc[3][3]), 64'd24);

        // Write and start while busy are both ignored
        run_pass(1);
        idle_check(8);
        run_pass(0);

        // Reset mid-stream, then replay the now-empty tiles
        run_pass(2);
        run_pass(0);
        chk("post_reset_result", 64'(pe_acc[3][3]), 64'd0);

        // Element write coinciding with start
        run_pass(3);

        // Random tiles
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = 16'($urandom);
                    mb[i][j] = 16'($urandom);
                end
            load_all();
            run_pass(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
